// File: rtl/sram_burst_reader_if.sv
// rtl/sram_burst_reader_if.sv - request, read-return and SRAM pin bundle for sram_burst_reader
interface sram_burst_reader_if #(
    parameter int LEN_W = 8
) ();
    // Request channel
    logic             req_valid;
    logic             req_ready;
    logic [19:0]      req_addr;
    logic [LEN_W-1:0] req_len;

    // Mem2IO data toward the reader
    logic [15:0]      mem_data;

    // Read-return channel
    logic [15:0]      rd_data;
    logic             rd_valid;
    logic             rd_last;
    logic             busy;

    // SRAM pins
    logic [19:0]      SRAM_ADDR;
    logic             SRAM_CE_N;
    logic             SRAM_OE_N;
    logic             SRAM_WE_N;

    // Requester plus memory side: issues bursts, supplies mem_data, consumes everything else
    modport master (
        output req_valid, req_addr, req_len, mem_data,
        input  req_ready, rd_data, rd_valid, rd_last, busy,
        input  SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N
    );

    // The burst reader itself
    modport slave (
        input  req_valid, req_addr, req_len, mem_data,
        output req_ready, rd_data, rd_valid, rd_last, busy,
        output SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N
    );
endinterface

// File: rtl/sram_burst_reader.sv
// rtl/sram_burst_reader.sv - burst read sequencer driving SRAM strobes and returning one word per beat
module sram_burst_reader #(
    parameter int WAIT_CYCLES = 1,
    parameter int LEN_W       = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    sram_burst_reader_if.slave bus
);
    // Wait counter only has to reach WAIT_CYCLES-1; keep it at least one bit wide.
    localparam int              WC_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic [WC_W-1:0]  wait_cnt;

    // This block never writes; the write strobe is tied inactive.
    assign bus.SRAM_WE_N = 1'b1;

    // Burst sequencer: every output is registered so the SRAM strobes and the
    // read-return pulse are glitch-free; CE_N/OE_N go low at the accept edge and
    // stay low across back-to-back words until the edge leaving the last CAPTURE.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state         <= IDLE;
            remaining     <= '0;
            wait_cnt      <= '0;
            bus.req_ready <= 1'b1;
            bus.busy      <= 1'b0;
            bus.rd_data   <= '0;
            bus.rd_valid  <= 1'b0;
            bus.rd_last   <= 1'b0;
            bus.SRAM_ADDR <= '0;
            bus.SRAM_CE_N <= 1'b1;
            bus.SRAM_OE_N <= 1'b1;
        end else begin
            // rd_valid/rd_last are single-cycle pulses; CAPTURE re-asserts them.
            bus.rd_valid <= 1'b0;
            bus.rd_last  <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        bus.SRAM_ADDR <= bus.req_addr;
                        remaining     <= bus.req_len;
                        bus.SRAM_CE_N <= 1'b0;
                        bus.SRAM_OE_N <= 1'b0;
                        bus.req_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        state         <= ADDR;
                    end
                end

                ADDR: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end

                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end

                CAPTURE: begin
                    // OE_N is still low here, so mem_data is the addressed word.
                    bus.rd_data  <= bus.mem_data;
                    bus.rd_valid <= 1'b1;
                    if (remaining != '0) begin
                        remaining     <= remaining - LEN_W'(1);
                        bus.SRAM_ADDR <= bus.SRAM_ADDR + 20'd1;
                        state         <= ADDR;
                    end else begin
                        // Final word: release the SRAM and reopen the request port
                        // at this same edge so a waiting request goes next cycle.
                        bus.rd_last   <= 1'b1;
                        bus.SRAM_CE_N <= 1'b1;
                        bus.SRAM_OE_N <= 1'b1;
                        bus.req_ready <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
